// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave sequencing a single-port SRAM macro with registered address and synchronous write.
// Sub-word writes become read-modify-write; a read that collides with a write cycle takes one wait state.
module ahb_sram_ctrl #(
  parameter int MEM_AW = 10
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [MEM_AW-1:0] sram_addr,
  output logic [31:0]       sram_data,
  output logic              sram_wren,
  input  logic [31:0]       sram_q
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_RMW_RD  = 3'd4,
    S_RMW_WR  = 3'd5,
    S_ERR1    = 3'd6,
    S_ERR2    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              acc_s;
  logic              err_s;
  logic              port_busy_s;
  logic              unused_s;

  assign unused_s = ^{HBURST, HADDR[31:MEM_AW+2]};

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [1:0]  lane,
    input logic [1:0]  size
  );
    logic [31:0] mask;
    mask = 32'h0000_0000;
    case (size)
      2'd0:    mask = 32'h0000_00FF << {lane, 3'b000};
      2'd1:    mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Transfer qualification and alignment check on the address phase
  always_comb begin
    acc_s       = HSEL & HREADY & HTRANS[1];
    err_s       = (HSIZE > 3'd2) |
                  ((HSIZE == 3'd1) & HADDR[0]) |
                  ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    port_busy_s = (state_q == S_WR) | (state_q == S_RMW_WR);
  end

  // Next-state: wait states advance unconditionally, all other states may accept
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    size_d  = size_q;
    case (state_q)
      S_RD_WAIT: state_d = S_RD;
      S_RMW_RD:  state_d = S_RMW_WR;
      S_ERR1:    state_d = S_ERR2;
      default: begin
        if (acc_s) begin
          addr_d = HADDR[MEM_AW+1:2];
          lane_d = HADDR[1:0];
          size_d = HSIZE[1:0];
          if (err_s) begin
            state_d = S_ERR1;
          end else if (HWRITE) begin
            state_d = (HSIZE == 3'd2) ? S_WR : S_RMW_RD;
          end else if (port_busy_s) begin
            // the read address could not be presented this cycle
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and latched address-phase attributes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= {MEM_AW{1'b0}};
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
    end
  end

  // Bus response and SRAM port drive decoded from state
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0000_0000;
    sram_wren = 1'b0;
    sram_data = 32'h0000_0000;
    sram_addr = HADDR[MEM_AW+1:2];
    case (state_q)
      S_RD: HRDATA = sram_q;
      S_RD_WAIT: begin
        HREADYOUT = 1'b0;
        sram_addr = addr_q;
      end
      S_WR: begin
        sram_wren = 1'b1;
        sram_addr = addr_q;
        sram_data = HWDATA;
      end
      S_RMW_RD: begin
        HREADYOUT = 1'b0;
        sram_addr = addr_q;
      end
      S_RMW_WR: begin
        sram_wren = 1'b1;
        sram_addr = addr_q;
        sram_data = merge_lanes(sram_q, HWDATA, lane_q, size_q);
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: HRDATA = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: pipelined AHB master, SRAM macro model and a transfer-level reference model.
module tb_ahb_sram_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [2:0]  HBURST = 3'd0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [9:0]  sram_addr;
  logic [31:0] sram_data;
  logic        sram_wren;
  logic [31:0] sram_q;

  ahb_sram_ctrl #(.MEM_AW(10)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .sram_addr(sram_addr),
    .sram_data(sram_data), .sram_wren(sram_wren), .sram_q(sram_q)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  // SRAM macro: registered address, synchronous write
  logic [31:0] sram_mem [0:1023];
  logic [9:0]  sram_areg;
  always @(posedge HCLK) begin
    if (sram_wren) sram_mem[sram_addr] <= sram_data;
    sram_areg <= sram_addr;
  end
  assign sram_q = sram_mem[sram_areg];

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        pend[$];
  txn_t        ap, dp;
  bit          dp_valid, advance, prev_write;
  int          dp_waits, dp_exp_waits;
  logic [31:0] ref_mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic        last_resp;
  int          last_waits;
  bit          rst_window = 1'b0;
  int          wren_hits = 0;

  always @(posedge HCLK) if (rst_window && sram_wren) wren_hits <= wren_hits + 1;

  function automatic txn_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.sel = sel; t.trans = trans; t.write = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic bit is_err(input txn_t t);
    return (t.size > 3'd2) || ((t.addr % (32'd1 << t.size)) != 32'd0);
  endfunction

  function automatic void apply_write(input txn_t t);
    int nb, idx;
    nb  = 1 << t.size;
    idx = int'(t.addr[11:2]);
    for (int b = 0; b < 4; b++)
      if (b / nb == int'(t.addr[1:0]) / nb) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the edge, check and hand over on the falling edge
  task automatic step();
    @(posedge HCLK); #1;
    if (advance) begin
      ap = (pend.size() > 0) ? pend.pop_front() : mk(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      HSEL = ap.sel; HTRANS = ap.trans; HWRITE = ap.write; HSIZE = ap.size; HADDR = ap.addr;
      HBURST = 3'($urandom_range(0, 7));
    end
    HWDATA = dp_valid ? dp.wdata : $urandom();
    @(negedge HCLK);
    if (dp_valid) begin
      if (!HREADYOUT) begin
        dp_waits++;
        chk("wait_resp", {31'h0, HRESP}, {31'h0, is_err(dp)});
        chk("wait_rdata", HRDATA, 32'h0);
        if (dp_waits > 3) begin
          chk("wait_bound", dp_waits, dp_exp_waits);
          dp_valid = 1'b0;
        end
      end else begin
        chk("waits", dp_waits, dp_exp_waits);
        chk("resp", {31'h0, HRESP}, {31'h0, is_err(dp)});
        last_waits = dp_waits;
        last_resp  = HRESP;
        if (!is_err(dp) && !dp.write) begin
          chk("rdata", HRDATA, ref_mem[dp.addr[11:2]]);
          last_rdata = HRDATA;
        end else begin
          chk("rdata_zero", HRDATA, 32'h0);
        end
        if (dp.write && !is_err(dp)) apply_write(dp);
      end
    end else begin
      chk("idle_ready", {31'h0, HREADYOUT}, 32'h1);
      chk("idle_resp", {31'h0, HRESP}, 32'h0);
      chk("idle_rdata", HRDATA, 32'h0);
    end
    if (HREADYOUT) begin
      prev_write = dp_valid && dp.write && !is_err(dp);
      advance = 1'b1;
      if (ap.sel && ap.trans[1]) begin
        dp = ap;
        dp_valid = 1'b1;
        dp_waits = 0;
        dp_exp_waits = (is_err(ap) || (ap.write && ap.size != 3'd2) || (!ap.write && prev_write)) ? 1 : 0;
      end else begin
        dp_valid = 1'b0;
      end
    end else begin
      advance = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || dp_valid) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pend.size() > 0 || dp_valid) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d cycles required=fewer than %0d", n, budget);
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    dp_valid = 1'b0; advance = 1'b1; prev_write = 1'b0;
    ap = mk(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    #12;
    chk("rst_ready", {31'h0, HREADYOUT}, 32'h1);
    chk("rst_resp", {31'h0, HRESP}, 32'h0);
    chk("rst_rdata", HRDATA, 32'h0);
    chk("rst_wren", {31'h0, sram_wren}, 32'h0);
    @(negedge HCLK); HRESETn = 1'b1;

    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF));
    pend.push_back(mk(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'h0));
    drain(50);
    chk("s1_rdata", last_rdata, 32'hDEADBEEF);
    chk("s1_waits", last_waits, 0);

    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0020, 32'h12345678));
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0020, 32'h0));
    drain(50);
    chk("s2_rdata", last_rdata, 32'h12345678);
    chk("s2_waits", last_waits, 1);

    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0030, 32'h11223344));
    pend.push_back(mk(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0));
    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0031, 32'h0000AA00));
    drain(50);
    chk("s3_bwr_waits", last_waits, 1);
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0030, 32'h0));
    drain(50);
    chk("s3_rdata", last_rdata, 32'h1122AA44);

    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0033, 32'hFFFF_FFFF));
    drain(50);
    chk("s4_resp", {31'h0, last_resp}, 32'h1);
    chk("s4_waits", last_waits, 1);
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0030, 32'h0));
    drain(50);
    chk("s4_rdata", last_rdata, 32'h1122AA44);

    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd3, 32'h0000_0010, 32'h0));
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'h0));
    drain(50);
    chk("s5_resp", {31'h0, last_resp}, 32'h0);
    chk("s5_rdata", last_rdata, 32'hDEADBEEF);

    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0040, 32'hCAFEF00D));
    drain(50);
    pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0041, 32'h00005500));
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      step();
      found = dp_valid && dp.write && (dp.size == 3'd0);
    end
    chk("s6_found", {31'h0, found}, 32'h1);
    step();
    rst_window = 1'b1;
    #2 HRESETn = 1'b0;
    #1;
    chk("s6_wren_async", {31'h0, sram_wren}, 32'h0);
    chk("s6_ready_rst", {31'h0, HREADYOUT}, 32'h1);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    dp_valid = 1'b0; advance = 1'b1; prev_write = 1'b0;
    ap = mk(1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) step();
    rst_window = 1'b0;
    chk("s6_wren_hits", wren_hits, 0);
    chk("s6_mem", sram_mem[16], 32'hCAFEF00D);
    pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0040, 32'h0));
    drain(50);
    chk("s6_rdata", last_rdata, 32'hCAFEF00D);

    for (int i = 0; i < 16; i++)
      pend.push_back(mk(1'b1, 2'b10, 1'b1, 3'd2, {26'h0, 4'(i), 2'b00}, $urandom()));
    drain(100);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] up;
      logic [3:0]  idx;
      logic [1:0]  low, tr;
      logic [2:0]  sz;
      logic        sel, wr;
      int          r;
      up  = $urandom();
      idx = 4'($urandom_range(0, 15));
      r   = $urandom_range(0, 19);
      if (r < 6) sz = 3'd0;
      else if (r < 12) sz = 3'd1;
      else if (r < 19) sz = 3'd2;
      else sz = 3'($urandom_range(3, 7));
      if (sz == 3'd0) low = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) low = {1'($urandom_range(0, 1)), 1'b0};
      else low = 2'b00;
      if ($urandom_range(0, 9) == 0) low = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r < 3) tr = 2'b00;
      else if (r < 4) tr = 2'b01;
      else if (r < 12) tr = 2'b10;
      else tr = 2'b11;
      sel = ($urandom_range(0, 9) != 0);
      wr  = 1'($urandom_range(0, 1));
      pend.push_back(mk(sel, tr, wr, sz, {up[31:12], 6'b0, idx, low}, $urandom()));
    end
    drain(2000);

    for (int i = 0; i < 16; i++)
      pend.push_back(mk(1'b1, 2'b10, 1'b0, 3'd2, {26'h0, 4'(i), 2'b00}, 32'h0));
    drain(100);
    for (int i = 0; i < 16; i++) chk("final_mem", sram_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
